// File: rtl/instr_encoder.sv
// Streaming instruction encoder and program loader.
// Accepts (mnemonic, operand) beats over valid/ready, checks each operand
// against the opcode map and writes the packed 8-bit word to sequential
// instruction-memory addresses starting at base_addr.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no session since reset; waiting for start
// RUN   | session active; beats accepted and written one per cycle
// DONE  | HALT written; done held until the next start
// ERR   | session aborted (bad mnemonic, bad operand, address overflow)

module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [7:0]        in_operand,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Mnemonic indices as presented on in_mnem.
    localparam logic [4:0] M_ADD  = 5'd0;
    localparam logic [4:0] M_ADDC = 5'd1;
    localparam logic [4:0] M_SUB  = 5'd2;
    localparam logic [4:0] M_SUBC = 5'd3;
    localparam logic [4:0] M_LSL  = 5'd4;
    localparam logic [4:0] M_LSLC = 5'd5;
    localparam logic [4:0] M_LSR  = 5'd6;
    localparam logic [4:0] M_LSRC = 5'd7;
    localparam logic [4:0] M_ASR  = 5'd8;
    localparam logic [4:0] M_NEG  = 5'd9;
    localparam logic [4:0] M_AND  = 5'd10;
    localparam logic [4:0] M_OR   = 5'd11;
    localparam logic [4:0] M_CMP  = 5'd12;
    localparam logic [4:0] M_LW   = 5'd13;
    localparam logic [4:0] M_SW   = 5'd14;
    localparam logic [4:0] M_ALW  = 5'd15;
    localparam logic [4:0] M_ASW  = 5'd16;
    localparam logic [4:0] M_HALT = 5'd17;
    localparam logic [4:0] M_IMME = 5'd18;
    localparam logic [4:0] M_BLT  = 5'd19;
    localparam logic [4:0] M_BNE  = 5'd20;

    localparam logic [1:0] E_NONE = 2'b00;
    localparam logic [1:0] E_MNEM = 2'b01;
    localparam logic [1:0] E_OPND = 2'b10;
    localparam logic [1:0] E_OVFL = 2'b11;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;

    logic [7:0]        enc_word;
    logic              mnem_ok;
    logic              opnd_ok;
    logic              is_halt;
    logic              reg_ok;
    logic              bit_ok;
    logic              imm_ok;
    logic              br_ok;
    logic              fire;

    // Operand range classes shared by several mnemonics.
    always_comb begin
        reg_ok = (in_operand[7:3] == 5'd0);
        bit_ok = (in_operand[7:1] == 7'd0);
        imm_ok = (in_operand[7:6] == 2'd0);
        // -16..15 in two's complement: top nibble all zeros or all ones.
        br_ok  = (in_operand[7:4] == 4'h0) || (in_operand[7:4] == 4'hF);
    end

    // Opcode map: packed word plus mnemonic/operand legality for the current beat.
    always_comb begin
        enc_word = 8'h00;
        mnem_ok  = 1'b1;
        opnd_ok  = 1'b1;
        is_halt  = 1'b0;
        case (in_mnem)
            M_ADD, M_ADDC, M_SUB, M_SUBC, M_LSL, M_LSLC,
            M_LSR, M_LSRC, M_ASR, M_NEG, M_AND, M_OR: begin
                // These mnemonic indices equal their 5-bit opcodes.
                enc_word = {in_mnem, in_operand[2:0]};
                opnd_ok  = reg_ok;
            end
            M_CMP: begin
                enc_word = {5'b01110, in_operand[2:0]};
                // CMP r0 would encode as 0x70, which is HALT.
                opnd_ok  = reg_ok && (in_operand[2:0] != 3'd0);
            end
            M_LW: begin
                enc_word = {5'b01101, in_operand[2:0]};
                opnd_ok  = reg_ok;
            end
            M_SW: begin
                enc_word = {5'b01100, in_operand[2:0]};
                opnd_ok  = reg_ok;
            end
            M_ALW: begin
                enc_word = {7'b0111110, in_operand[0]};
                opnd_ok  = bit_ok;
            end
            M_ASW: begin
                enc_word = {7'b0111111, in_operand[0]};
                opnd_ok  = bit_ok;
            end
            M_HALT: begin
                enc_word = 8'h70;
                is_halt  = 1'b1;
            end
            M_IMME: begin
                enc_word = {2'b10, in_operand[5:0]};
                opnd_ok  = imm_ok;
            end
            M_BLT: begin
                enc_word = {3'b110, in_operand[4:0]};
                opnd_ok  = br_ok;
            end
            M_BNE: begin
                enc_word = {3'b111, in_operand[4:0]};
                opnd_ok  = br_ok;
            end
            default: begin
                mnem_ok = 1'b0;
                opnd_ok = 1'b0;
            end
        endcase
    end

    assign fire = in_valid && (state_q == S_RUN);

    // Next state and next values of the session registers and write port.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = base_addr;
                    count_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    code_d  = E_NONE;
                end
            end
            S_RUN: begin
                if (fire) begin
                    if (!mnem_ok) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = E_MNEM;
                    end else if (!opnd_ok) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = E_OPND;
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = enc_word;
                        count_d = count_q + CNT_ONE;
                        if (is_halt) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else if (addr_q == ADDR_TOP) begin
                            // Last word fits, but the next one would wrap.
                            state_d = S_ERR;
                            err_d   = 1'b1;
                            code_d  = E_OVFL;
                        end else begin
                            addr_d = addr_q + ADDR_ONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Session registers and registered write port; reset drops any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= E_NONE;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign in_ready   = (state_q == S_RUN);
    assign busy       = (state_q == S_RUN);
    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = code_q;
    assign count      = count_q;

endmodule
